// File: rtl/imem_load_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// imem_load_ctrl_pkg
//  Shared definitions for the instruction-memory load controller: default
//  geometry, the halt opcode (also the imem fill value), the controller state
//  encoding and an address-width helper.
// -----------------------------------------------------------------------------
package imem_load_ctrl_pkg;

   localparam int          NB_INST_DEF   = 32;
   localparam int          NB_BYTE_DEF   = 8;
   localparam int          MEM_SIZEB_DEF = 128;
   localparam logic [31:0] HALT_WORD_DEF = 32'hF800_0000;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CLEAR = 2'd1,
      ST_LOAD  = 2'd2,
      ST_RUN   = 2'd3
   } state_e;

   // Word-address width for a memory of 'depth' words (at least one bit).
   function automatic int addr_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/imem_load_ctrl_if.sv
// -----------------------------------------------------------------------------
// imem_load_ctrl_if
//  Instruction-memory port shared by the load controller and the imem.
//  Signals:
//   mem_we    write enable, one-cycle pulse per written word
//   mem_re    read enable for instruction fetch
//   mem_addr  word address
//   mem_wdata write data
//  Modports: master = controller (drives the port), slave = memory.
// -----------------------------------------------------------------------------
interface imem_load_ctrl_if #(
   parameter int NB_INST = 32,
   parameter int ADDRW   = 7
);

   logic               mem_we;
   logic               mem_re;
   logic [ADDRW-1:0]   mem_addr;
   logic [NB_INST-1:0] mem_wdata;

   modport master (output mem_we, mem_re, mem_addr, mem_wdata);
   modport slave  (input  mem_we, mem_re, mem_addr, mem_wdata);

endinterface

// File: rtl/imem_load_ctrl_byte_packer.sv
// -----------------------------------------------------------------------------
// imem_load_ctrl_byte_packer
//  Packs a big-endian byte stream into words: the first byte of a word lands
//  in the most significant position. Emits the finished word together with a
//  one-cycle word_valid in the cycle after its last byte is accepted.
//  Ports:
//   i_clk, i_reset   clock, asynchronous active-high reset
//   i_clear          discard the partial word and restart at byte 0
//   i_byte_valid     accept i_byte this cycle
//   i_byte           stream byte
//   o_word           last completed word (held until the next one)
//   o_word_valid     one-cycle pulse: o_word is new
// -----------------------------------------------------------------------------
module imem_load_ctrl_byte_packer #(
   parameter int NB_INST = 32,
   parameter int NB_BYTE = 8
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic               i_clear,
   input  logic               i_byte_valid,
   input  logic [NB_BYTE-1:0] i_byte,
   output logic [NB_INST-1:0] o_word,
   output logic               o_word_valid
);

   localparam int NB_PER_WORD = NB_INST / NB_BYTE;
   localparam int IDXW        = $clog2(NB_PER_WORD);
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NB_PER_WORD - 1);

   logic [IDXW-1:0]            idx_q;
   // Holds the leading bytes of the word being assembled; the final byte goes
   // straight into o_word, so a new word can start while o_word is on the bus.
   logic [NB_INST-NB_BYTE-1:0] asm_q;

   // NOTE: state is updated with non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         // NOTE: the assembly register is small and datapath-visible, so it is
         // reset explicitly; the imem itself is never reset by this block.
         idx_q        <= '0;
         asm_q        <= '0;
         o_word       <= '0;
         o_word_valid <= 1'b0;
      end else if (i_clear) begin
         idx_q        <= '0;
         asm_q        <= '0;
         o_word_valid <= 1'b0;
      end else begin
         o_word_valid <= 1'b0;
         if (i_byte_valid) begin
            asm_q <= {asm_q[NB_INST-2*NB_BYTE-1:0], i_byte};
            if (idx_q == LAST_IDX) begin
               o_word       <= {asm_q, i_byte};
               o_word_valid <= 1'b1;
               idx_q        <= '0;
            end else begin
               idx_q <= idx_q + 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/imem_load_ctrl.sv
// -----------------------------------------------------------------------------
// imem_load_ctrl
//  Owns the instruction-memory port. On i_load_start it loads a program from a
//  byte stream (debug UART RX) into imem at sequential word addresses from 0,
//  stops on the halt word or when the memory is full, then hands the port to
//  instruction fetch and enables the pipeline.
//  Build option: define IMEM_CLEAR_EN to fill imem with HALT_WORD (CLEAR state)
//  before every load; without it the load starts directly and stale words
//  beyond the new program remain.
//  Ports:
//   i_clk, i_reset   clock, asynchronous active-high reset
//   i_load_start     pulse: start or restart a program load
//   i_rx_valid/data  stream byte, at most one per cycle
//   i_fetch_en       fetch read request (honoured in RUN only)
//   i_pc_addr        fetch word address
//   mem              imem port (we/re/addr/wdata), master side
//   o_loading        high in CLEAR/LOAD
//   o_pipe_en        high while in RUN (registered)
//   o_word_count     words written in the current load
//   o_overflow       sticky: memory filled before a halt word arrived
// -----------------------------------------------------------------------------
module imem_load_ctrl
   import imem_load_ctrl_pkg::*;
#(
   parameter int                 NB_INST   = NB_INST_DEF,
   parameter int                 NB_BYTE   = NB_BYTE_DEF,
   parameter int                 MEM_SIZEB = MEM_SIZEB_DEF,
   parameter logic [NB_INST-1:0] HALT_WORD = HALT_WORD_DEF,
   localparam int                ADDRW     = addr_width(MEM_SIZEB)
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic               i_load_start,
   input  logic               i_rx_valid,
   input  logic [NB_BYTE-1:0] i_rx_data,
   input  logic               i_fetch_en,
   input  logic [ADDRW-1:0]   i_pc_addr,
   imem_load_ctrl_if.master   mem,
   output logic               o_loading,
   output logic               o_pipe_en,
   output logic [ADDRW:0]     o_word_count,
   output logic               o_overflow
);

   localparam logic [ADDRW-1:0] LAST_ADDR = ADDRW'(MEM_SIZEB - 1);

`ifdef IMEM_CLEAR_EN
   localparam state_e START_ST = ST_CLEAR;
`else
   localparam state_e START_ST = ST_LOAD;
`endif

   state_e             state_q, state_d;
   logic [ADDRW-1:0]   ptr_q;
   logic [ADDRW:0]     count_q;
   logic               ovf_q;
   logic               pipe_en_q;

   logic               byte_accept;
   logic [NB_INST-1:0] word;
   logic               word_valid;
   logic               word_done;
   logic               last_slot;

   // A restart in the same cycle as a byte drops that byte.
   assign byte_accept = i_rx_valid && (state_q == ST_LOAD) && !i_load_start;

   imem_load_ctrl_byte_packer #(
      .NB_INST (NB_INST),
      .NB_BYTE (NB_BYTE)
   ) u_packer (
      .i_clk        (i_clk),
      .i_reset      (i_reset),
      .i_clear      (i_load_start),
      .i_byte_valid (byte_accept),
      .i_byte       (i_rx_data),
      .o_word       (word),
      .o_word_valid (word_valid)
   );

   // A packed word is on the bus this cycle (completes even if a restart
   // arrives in the same cycle).
   assign word_done = word_valid && (state_q == ST_LOAD);
   assign last_slot = (ptr_q == LAST_ADDR);

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      // NOTE: every combinational output gets a default first, so no path can
      // leave it unassigned and infer a latch.
      state_d = state_q;
      if (i_load_start) begin
         state_d = START_ST;
      end else begin
         case (state_q)
            ST_CLEAR: if (last_slot) state_d = ST_LOAD;
            ST_LOAD:  if (word_done && (word == HALT_WORD || last_slot)) state_d = ST_RUN;
            default:  state_d = state_q;
         endcase
      end
   end

   // Pointer, count, overflow flag and the registered pipeline enable.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         ptr_q     <= '0;
         count_q   <= '0;
         ovf_q     <= 1'b0;
         pipe_en_q <= 1'b0;
      end else begin
         pipe_en_q <= (state_d == ST_RUN);
         if (i_load_start) begin
            ptr_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
         end else if (state_q == ST_CLEAR) begin
            ptr_q <= last_slot ? '0 : ptr_q + 1'b1;
         end else if (word_done) begin
            count_q <= count_q + 1'b1;
            // The pointer parks on the last slot instead of wrapping.
            if (last_slot) begin
               ovf_q <= (word != HALT_WORD);
            end else begin
               ptr_q <= ptr_q + 1'b1;
            end
         end
      end
   end

   // imem port mux: the loader owns the address in CLEAR/LOAD, fetch in RUN.
   always_comb begin
      mem.mem_we    = 1'b0;
      mem.mem_addr  = '0;
      mem.mem_wdata = word;
      case (state_q)
         ST_CLEAR: begin
            mem.mem_we    = 1'b1;
            mem.mem_addr  = ptr_q;
            mem.mem_wdata = HALT_WORD;
         end
         ST_LOAD: begin
            mem.mem_we   = word_done;
            mem.mem_addr = ptr_q;
         end
         ST_RUN: begin
            mem.mem_addr = i_pc_addr;
         end
         default: begin
            mem.mem_addr = '0;
         end
      endcase
   end

   // Same-cycle read enable: imem samples the request on the falling edge.
   assign mem.mem_re   = i_fetch_en && (state_q == ST_RUN);
   assign o_loading    = (state_q == ST_CLEAR) || (state_q == ST_LOAD);
   assign o_pipe_en    = pipe_en_q;
   assign o_word_count = count_q;
   assign o_overflow   = ovf_q;

endmodule
